// File: rtl/ol_link_if.sv
// Parallel transceiver port bundle for the optical-link controller.
// The master side is the controller; the slave side is the transceiver.
interface ol_link_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0]   data_out;
  logic                ena_tx;
  logic [DATA_W/8-1:0] datak;
  logic [DATA_W-1:0]   data_rx;
  logic                ena_rx;

  modport master (output data_out, ena_tx, datak, input data_rx, ena_rx);
  modport slave  (input data_out, ena_tx, datak, output data_rx, ena_rx);
endinterface

// File: rtl/ol_link_ctrl.sv
// Optical-link bring-up controller: comma alignment, counter link test with
// echo check, then pass-through data mode with loss-of-link re-alignment.
module ol_link_ctrl #(
  parameter int          DATA_W         = 16,
  parameter logic [7:0]  K_CHAR         = 8'hBC,
  parameter logic [7:0]  ALIGN_FILL     = 8'h50,
  parameter int          ALIGN_K_CYC    = 1040000,
  parameter int          ALIGN_IDLE_CYC = 4368,
  parameter int          TEST_CYC       = 4369,
  parameter int          LOCK_RUN       = 2047,
  parameter int          LOSS_CYC       = 256,
  parameter int          TMR_W          = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              live,
  input  logic              relink,
  input  logic [DATA_W-1:0] data_tx,
  ol_link_if.master         xcvr,
  output logic              error,
  output logic              send_err,
  output logic [1:0]        state,
  output logic [15:0]       err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int LOSS_W = $clog2(LOSS_CYC + 1);

  localparam logic [TMR_W-1:0]    K_END      = TMR_W'(ALIGN_K_CYC);
  localparam logic [TMR_W-1:0]    ALIGN_END  = TMR_W'(ALIGN_K_CYC + ALIGN_IDLE_CYC - 1);
  localparam logic [TMR_W-1:0]    TEST_END   = TMR_W'(TEST_CYC - 1);
  localparam logic [RUN_W-1:0]    RUN_MAX    = RUN_W'(LOCK_RUN);
  localparam logic [LOSS_W-1:0]   LOSS_END   = LOSS_W'(LOSS_CYC - 1);
  localparam logic [DATA_W-1:0]   ALIGN_WORD = {(DATA_W/16){ALIGN_FILL, K_CHAR}};
  localparam logic [DATA_W/8-1:0] ALIGN_K    = {(DATA_W/16){2'b01}};

  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_TEST  = 2'd1,
    ST_DATA  = 2'd2,
    ST_ILL   = 2'd3
  } state_t;

  state_t              state_q;
  logic [TMR_W-1:0]    timer;
  logic [DATA_W-1:0]   tx_cnt;
  logic [DATA_W-1:0]   prev_rx;
  logic                prev_vld;
  logic [RUN_W-1:0]    run;
  logic                lock;
  logic [LOSS_W-1:0]   loss;

  logic [DATA_W-1:0]   rx_inc;
  logic                good_cmp;
  logic [RUN_W-1:0]    run_nxt;
  logic                lock_nxt;
  logic                to_align;

  assign state = state_q;

  // Echo check: a word is good when it is one more than the last word seen.
  always_comb begin
    rx_inc   = prev_rx + 1'b1;
    good_cmp = xcvr.ena_rx && (xcvr.data_rx == rx_inc);
    run_nxt  = run;
    if (prev_vld) begin
      if (good_cmp) run_nxt = (run == RUN_MAX) ? run : run + 1'b1;
      else          run_nxt = '0;
    end
    lock_nxt = lock || (run_nxt == RUN_MAX);
    to_align = !live || relink || (state_q == ST_ILL) ||
               ((state_q == ST_DATA) && !xcvr.ena_rx && (loss == LOSS_END));
  end

  // Received-word history is pure data; its validity is tracked by prev_vld.
  always_ff @(posedge clk) begin
    prev_rx <= xcvr.data_rx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ALIGN;
      timer         <= '0;
      xcvr.data_out <= '0;
      xcvr.ena_tx   <= 1'b1;
      xcvr.datak    <= '0;
      error         <= 1'b1;
      send_err      <= 1'b0;
      err_cnt       <= '0;
      tx_cnt        <= '0;
      prev_vld      <= 1'b0;
      run           <= '0;
      lock          <= 1'b0;
      loss          <= '0;
    end else begin
      send_err <= 1'b0;
      if (to_align) begin
        // Transmit outputs hold for this cycle; the comma run starts next cycle.
        state_q  <= ST_ALIGN;
        timer    <= '0;
        error    <= 1'b1;
        err_cnt  <= '0;
        tx_cnt   <= '0;
        prev_vld <= 1'b0;
        run      <= '0;
        lock     <= 1'b0;
        loss     <= '0;
      end else begin
        case (state_q)
          ST_ALIGN: begin
            xcvr.data_out <= ALIGN_WORD;
            if (timer < K_END) begin
              xcvr.ena_tx <= 1'b0;
              xcvr.datak  <= ALIGN_K;
            end else begin
              xcvr.ena_tx <= 1'b1;
              xcvr.datak  <= '0;
            end
            if (timer == ALIGN_END) begin
              state_q <= ST_TEST;
              timer   <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_TEST: begin
            xcvr.ena_tx   <= 1'b1;
            xcvr.datak    <= '0;
            xcvr.data_out <= tx_cnt;
            tx_cnt        <= tx_cnt + 1'b1;
            prev_vld      <= 1'b1;
            run           <= run_nxt;
            lock          <= lock_nxt;
            if (prev_vld && !good_cmp && lock && (err_cnt != 16'hFFFF))
              err_cnt <= err_cnt + 1'b1;
            if (timer == TEST_END) begin
              send_err <= 1'b1;
              error    <= !(lock_nxt && xcvr.ena_rx);
              state_q  <= ST_DATA;
              timer    <= '0;
              loss     <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_DATA: begin
            xcvr.ena_tx   <= 1'b1;
            xcvr.datak    <= '0;
            xcvr.data_out <= data_tx;
            if (xcvr.ena_rx) loss <= '0;
            else             loss <= loss + 1'b1;
          end
          default: state_q <= ST_ALIGN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ol_link_ctrl.sv
// Directed bench for ol_link_ctrl with short phase lengths and a loopback
// transceiver model (optional offset and corruption on the echoed word).
module tb_ol_link_ctrl;

  logic        clk;
  logic        rst_n;
  logic        live;
  logic        relink;
  logic [15:0] data_tx;
  logic        error;
  logic        send_err;
  logic [1:0]  state;
  logic [15:0] err_cnt;

  logic        loop_en;
  logic [15:0] rx_off;
  logic [15:0] corrupt;
  logic [15:0] rx_fixed;

  int checks;
  int failures;

  ol_link_if #(.DATA_W(16)) lk ();

  assign lk.data_rx = loop_en ? ((lk.data_out + rx_off) ^ corrupt) : rx_fixed;

  ol_link_ctrl #(
    .DATA_W(16), .K_CHAR(8'hBC), .ALIGN_FILL(8'h50),
    .ALIGN_K_CYC(8), .ALIGN_IDLE_CYC(4), .TEST_CYC(64),
    .LOCK_RUN(16), .LOSS_CYC(4), .TMR_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .live(live), .relink(relink),
    .data_tx(data_tx), .xcvr(lk.master),
    .error(error), .send_err(send_err), .state(state), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the ALIGN entry edge: n edges later the state is TEST.
  task automatic align_to_test(input string tag, input int n);
    tick(n - 1);
    chk({tag, "_still_align"}, state, 0);
    tick(1);
    chk({tag, "_enter_test"}, state, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},    state, 0);
    chk({tag, "_data_out"}, lk.data_out, 16'h0000);
    chk({tag, "_ena_tx"},   lk.ena_tx, 1);
    chk({tag, "_datak"},    lk.datak, 0);
    chk({tag, "_error"},    error, 1);
    chk({tag, "_send_err"}, send_err, 0);
    chk({tag, "_err_cnt"},  err_cnt, 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; live = 1'b1; relink = 1'b0; data_tx = 16'h0000;
    lk.ena_rx = 1'b1;
    loop_en = 1'b1; rx_off = 16'h0000; corrupt = 16'h0000; rx_fixed = 16'h0000;

    tick(2);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // 1: comma run then idle, then TEST
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      chk("align_k_data", lk.data_out, 16'h50BC);
      chk("align_k_datak", lk.datak, 2'b01);
      chk("align_k_enatx", lk.ena_tx, 0);
    end
    for (int e = 9; e <= 11; e++) begin
      tick(1);
      chk("align_idle_enatx", lk.ena_tx, 1);
      chk("align_idle_datak", lk.datak, 0);
    end
    chk("align_state11", state, 0);
    tick(1);
    chk("align_state12", state, 1);

    // 2: clean loopback, lock, good verdict, pass-through
    tick(6);
    chk("test_cnt5", lk.data_out, 16'd5);
    tick(11);
    chk("lock_before", dut.lock, 0);
    tick(1);
    chk("lock_after", dut.lock, 1);
    tick(45);
    chk("pre_verdict_state", state, 1);
    chk("pre_verdict_send", send_err, 0);
    chk("pre_verdict_error", error, 1);
    tick(1);
    chk("verdict_send", send_err, 1);
    chk("verdict_error", error, 0);
    chk("verdict_state", state, 2);
    chk("verdict_errcnt", err_cnt, 0);
    data_tx = 16'hA5A5;
    tick(1);
    chk("data_pass", lk.data_out, 16'hA5A5);
    chk("send_pulse_end", send_err, 0);

    // 5: short dropout tolerated, full dropout re-aligns
    lk.ena_rx = 1'b0;
    tick(3);
    lk.ena_rx = 1'b1;
    tick(1);
    chk("loss3_stays", state, 2);
    lk.ena_rx = 1'b0;
    tick(3);
    chk("loss_pre", state, 2);
    tick(1);
    chk("loss4_state", state, 0);
    chk("loss4_error", error, 1);
    lk.ena_rx = 1'b1;
    tick(1);
    chk("loss4_datak", lk.datak, 2'b01);
    chk("loss4_enatx", lk.ena_tx, 0);
    align_to_test("relock1", 11);

    // 3a: one corrupted echo in the verdict cycle after lock
    tick(63);
    corrupt = 16'h0100;
    tick(1);
    corrupt = 16'h0000;
    chk("corr_errcnt", err_cnt, 1);
    chk("corr_error", error, 0);
    chk("corr_send", send_err, 1);
    chk("corr_state", state, 2);

    // 6a: relink from DATA
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    chk("relink_state", state, 0);
    chk("relink_errcnt", err_cnt, 0);
    chk("relink_error", error, 1);
    tick(1);
    chk("relink_datak", lk.datak, 2'b01);
    align_to_test("relink", 11);

    // 3b: offset loopback wrapping FFFF->0000, then ena_rx low at verdict
    rx_off = 16'hFFE8;
    tick(63);
    chk("wrap_errcnt", err_cnt, 0);
    lk.ena_rx = 1'b0;
    tick(1);
    lk.ena_rx = 1'b1;
    rx_off = 16'h0000;
    chk("norx_error", error, 1);
    chk("norx_send", send_err, 1);
    chk("norx_errcnt", err_cnt, 1);
    chk("norx_state", state, 2);

    // live=0 from DATA, then relink in the verdict cycle
    live = 1'b0;
    tick(1);
    live = 1'b1;
    chk("live_data_state", state, 0);
    align_to_test("live1", 12);
    tick(63);
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    chk("relink_verdict_send", send_err, 0);
    chk("relink_verdict_state", state, 0);
    chk("relink_verdict_error", error, 1);

    // 4: constant echo never locks
    loop_en = 1'b0;
    rx_fixed = 16'h1234;
    align_to_test("const", 12);
    tick(64);
    chk("const_error", error, 1);
    chk("const_send", send_err, 1);
    chk("const_errcnt", err_cnt, 0);
    chk("const_lock", dut.lock, 0);
    chk("const_state", state, 2);
    loop_en = 1'b1;

    // 6b: live=0 (with relink) in TEST, held off for a while
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    align_to_test("live2", 12);
    tick(30);
    live = 1'b0;
    relink = 1'b1;
    tick(1);
    relink = 1'b0;
    chk("liveoff_state", state, 0);
    chk("liveoff_error", error, 1);
    for (int i = 0; i < 70; i++) begin
      chk("liveoff_send", send_err, 0);
      tick(1);
    end
    chk("liveoff_hold_state", state, 0);
    live = 1'b1;
    align_to_test("live3", 12);

    // 6c: errors after lock, then asynchronous reset mid-TEST
    tick(30);
    corrupt = 16'h0001;
    tick(1);
    corrupt = 16'h0000;
    tick(1);
    chk("mid_errcnt", err_cnt, 2);
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
